// File: rtl/note_pkg.sv
// -----------------------------------------------------------------------------
// note_pkg
// Shared definitions for the note tone player:
//   - note_code field slice positions (pitch / octave / length)
//   - FSM state encodings (legacy-compatible localparam constants)
//   - HALF_TABLE: half-period in clk cycles at 50 MHz for C4..B4, indexed by
//     pitch code (0 and 13..15 are rests and hold 0)
//   - helpers to classify rests and to compute a clamped half-period
// -----------------------------------------------------------------------------
package note_pkg;

  // note_code field slices
  localparam int PITCH_MSB = 7;
  localparam int PITCH_LSB = 4;
  localparam int OCT_MSB   = 3;
  localparam int OCT_LSB   = 2;
  localparam int LEN_MSB   = 1;
  localparam int LEN_LSB   = 0;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Half-period in clk cycles for each pitch code at octave 0.
  localparam logic [16:0] HALF_TABLE [0:15] = '{
    17'd0,
    17'd95556, 17'd90193, 17'd85131, 17'd80354,
    17'd75843, 17'd71586, 17'd67568, 17'd63776,
    17'd60197, 17'd56818, 17'd53629, 17'd50619,
    17'd0,     17'd0,     17'd0
  };

  // Pitch codes outside 1..12 are silent.
  function automatic logic is_rest(input logic [3:0] pitch);
    return (pitch == 4'd0) || (pitch > 4'd12);
  endfunction

  // Table lookup shifted by octave plus global shift; never below 2 so the
  // half-period counter always has a non-degenerate reload value.
  function automatic logic [16:0] half_period(input logic [3:0] pitch,
                                              input logic [1:0] oct,
                                              input int unsigned shift);
    logic [16:0] raw;
    raw = HALF_TABLE[pitch] >> (32'(oct) + shift);
    if (raw < 17'd2) begin
      return 17'd2;
    end else begin
      return raw;
    end
  endfunction

endpackage

// File: rtl/note_fifo.sv
// -----------------------------------------------------------------------------
// note_fifo
// Synchronous first-word-fall-through FIFO, DEPTH entries (power of 2, >= 2).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (flushes contents)
//   push, din       write request and data; ignored while full
//   pop             read request; ignored while empty
//   dout            head entry (valid while !empty)
//   full, empty     status flags
//   count           current number of stored entries
// -----------------------------------------------------------------------------
module note_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      if (push_ok_s && !pop_ok_s) begin
        count_r <= count_r + CW'(1);
      end else if (pop_ok_s && !push_ok_s) begin
        count_r <= count_r - CW'(1);
      end
    end
  end

  // Storage array; cleared on reset so stale codes never reach the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

endmodule

// File: rtl/note_tone_player.sv
// -----------------------------------------------------------------------------
// note_tone_player
// Accepts 8-bit note codes over valid/ready into a small FIFO and plays each
// one as a square wave on `tone` for beat_len * 2^len cycles, followed by a
// GAP_CYCLES silent articulation gap.
// note_code: [7:4] pitch (0, 13..15 rest; 1..12 C..B), [3:2] octave up,
//            [1:0] length code (1, 2, 4, 8 beats).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (silences, flushes FIFO)
//   note_valid   source presents note_code
//   note_code    note to enqueue
//   note_ready   FIFO not full (combinational from FIFO count)
//   speed        tempo: beat_len = BEAT_CYCLES >> speed, sampled at note start
//   pause        (only with NOTE_PAUSE_EN) freezes playback, forces tone low
//   tone         square-wave buzzer output
//   busy         playing, in the gap, or FIFO non-empty
//   cur_note     code currently sounding; 0 when idle
// Build option: define NOTE_PAUSE_EN to add the `pause` input.
// -----------------------------------------------------------------------------
module note_tone_player
  import note_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 500_000,
  parameter int TABLE_SHIFT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       note_valid,
  input  logic [7:0] note_code,
  output logic       note_ready,
  input  logic [2:0] speed,
`ifdef NOTE_PAUSE_EN
  input  logic       pause,
`endif
  output logic       tone,
  output logic       busy,
  output logic [7:0] cur_note
);

  localparam int DUR_W    = $clog2(BEAT_CYCLES * 8) + 1;
  localparam int GAP_LOAD = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int GAP_W    = $clog2(GAP_LOAD + 1);
  localparam int CNT_W    = $clog2(DEPTH) + 1;

  // FIFO interface
  logic             push_s;
  logic             pop_s;
  logic [7:0]       head_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [CNT_W-1:0] fifo_count_s;
  logic [CNT_W-1:0] count_nxt_s;

  // Playback state
  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [DUR_W-1:0] dur_cnt_r;
  logic [DUR_W-1:0] dur_nxt_s;
  logic [16:0]      half_cnt_r;
  logic [16:0]      half_nxt_s;
  logic [16:0]      half_load_r;
  logic [16:0]      half_load_nxt_s;
  logic [GAP_W-1:0] gap_cnt_r;
  logic [GAP_W-1:0] gap_nxt_s;
  logic             rest_r;
  logic             rest_nxt_s;
  logic             tone_r;
  logic             tone_nxt_s;
  logic [7:0]       cur_note_r;
  logic [7:0]       cur_nxt_s;
  logic             busy_r;
  logic             start_s;
  logic             pause_s;

  // Note-start load values derived from the FIFO head and current speed
  logic [DUR_W-1:0] beat_raw_s;
  logic [DUR_W-1:0] beat_len_s;
  logic [DUR_W-1:0] dur_load_s;
  logic [16:0]      half_load_s;

`ifdef NOTE_PAUSE_EN
  assign pause_s = pause;
`else
  assign pause_s = 1'b0;
`endif

  assign note_ready = !fifo_full_s;
  assign push_s     = note_valid && note_ready;
  assign tone       = tone_r;
  assign busy       = busy_r;
  assign cur_note   = cur_note_r;

  note_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .din   (note_code),
    .pop   (pop_s),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Duration and half-period for the note at the FIFO head.
  always_comb begin
    beat_raw_s  = DUR_W'(BEAT_CYCLES) >> speed;
    beat_len_s  = (beat_raw_s == {DUR_W{1'b0}}) ? DUR_W'(1) : beat_raw_s;
    dur_load_s  = beat_len_s << head_s[LEN_MSB:LEN_LSB];
    half_load_s = half_period(head_s[PITCH_MSB:PITCH_LSB],
                              head_s[OCT_MSB:OCT_LSB],
                              TABLE_SHIFT);
  end

  // Playback FSM: IDLE -> PLAY -> GAP -> (PLAY | IDLE).
  always_comb begin
    state_nxt_s     = state_r;
    dur_nxt_s       = dur_cnt_r;
    half_nxt_s      = half_cnt_r;
    half_load_nxt_s = half_load_r;
    gap_nxt_s       = gap_cnt_r;
    rest_nxt_s      = rest_r;
    tone_nxt_s      = tone_r;
    cur_nxt_s       = cur_note_r;
    start_s         = 1'b0;
    pop_s           = 1'b0;

    case (state_r)
      ST_IDLE: begin
        tone_nxt_s = 1'b0;
        if (!fifo_empty_s && !pause_s) begin
          start_s = 1'b1;
        end else begin
          start_s = 1'b0;
        end
      end

      ST_PLAY: begin
        if (pause_s) begin
          // Counters hold; the tone restarts low when pause releases.
          tone_nxt_s = 1'b0;
        end else if (dur_cnt_r == DUR_W'(1)) begin
          state_nxt_s = ST_GAP;
          tone_nxt_s  = 1'b0;
          gap_nxt_s   = GAP_W'(GAP_LOAD);
        end else begin
          dur_nxt_s = dur_cnt_r - DUR_W'(1);
          if (half_cnt_r == 17'd1) begin
            half_nxt_s = half_load_r;
            tone_nxt_s = rest_r ? 1'b0 : !tone_r;
          end else begin
            half_nxt_s = half_cnt_r - 17'd1;
          end
        end
      end

      ST_GAP: begin
        tone_nxt_s = 1'b0;
        if (pause_s) begin
          gap_nxt_s = gap_cnt_r;
        end else if (gap_cnt_r == GAP_W'(1)) begin
          if (!fifo_empty_s) begin
            start_s = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
            cur_nxt_s   = 8'h00;
          end
        end else begin
          gap_nxt_s = gap_cnt_r - GAP_W'(1);
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
        tone_nxt_s  = 1'b0;
        cur_nxt_s   = 8'h00;
      end
    endcase

    // Note start shared by IDLE and back-to-back GAP exit.
    if (start_s) begin
      pop_s           = 1'b1;
      state_nxt_s     = ST_PLAY;
      cur_nxt_s       = head_s;
      dur_nxt_s       = dur_load_s;
      half_nxt_s      = half_load_s;
      half_load_nxt_s = half_load_s;
      rest_nxt_s      = is_rest(head_s[PITCH_MSB:PITCH_LSB]);
      tone_nxt_s      = 1'b0;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Next FIFO occupancy, so busy can be registered without a cycle of lag.
  always_comb begin
    count_nxt_s = fifo_count_s + CNT_W'(push_s) - CNT_W'(pop_s);
  end

  // Playback registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      dur_cnt_r   <= {DUR_W{1'b0}};
      half_cnt_r  <= 17'd0;
      half_load_r <= 17'd0;
      gap_cnt_r   <= {GAP_W{1'b0}};
      rest_r      <= 1'b0;
      tone_r      <= 1'b0;
      cur_note_r  <= 8'h00;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      dur_cnt_r   <= dur_nxt_s;
      half_cnt_r  <= half_nxt_s;
      half_load_r <= half_load_nxt_s;
      gap_cnt_r   <= gap_nxt_s;
      rest_r      <= rest_nxt_s;
      tone_r      <= tone_nxt_s;
      cur_note_r  <= cur_nxt_s;
      busy_r      <= (state_nxt_s != ST_IDLE) || (count_nxt_s != {CNT_W{1'b0}});
    end
  end

endmodule

// File: tb/tb_note_tone_player.sv
// -----------------------------------------------------------------------------
// tb_note_tone_player
// Self-checking bench for note_tone_player (DEPTH=4, BEAT_CYCLES=1000,
// GAP_CYCLES=20, TABLE_SHIFT=8). A timeline reference model tracks the notes
// held in the FIFO and the play-time position inside the sounding note; every
// cycle the DUT outputs are compared against it. Directed tasks add explicit
// checks on durations, high time, back-pressure, ordering and reset.
// -----------------------------------------------------------------------------
module tb_note_tone_player;

  localparam int DEPTH  = 4;
  localparam int BEAT   = 1000;
  localparam int GAP    = 20;
  localparam int SHIFT  = 8;
  localparam int BUDGET = 20000;
  localparam int TBL [0:15] = '{0, 95556, 90193, 85131, 80354, 75843, 71586,
                                67568, 63776, 60197, 56818, 53629, 50619,
                                0, 0, 0};

  logic       clk;
  logic       rst_n;
  logic       note_valid;
  logic [7:0] note_code;
  logic       note_ready;
  logic [2:0] speed;
  logic       pause;
  logic       tone;
  logic       busy;
  logic [7:0] cur_note;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_q [$];
  bit         m_active;
  logic [7:0] m_cur;
  bit         m_tone;
  bit         m_rest;
  int         m_t;
  int         m_d;
  int         m_h;

  // Observation helpers
  int         obs_busy;
  int         obs_high;
  logic [7:0] last_cur;
  logic [7:0] obs_notes [$];

  note_tone_player #(
    .DEPTH       (DEPTH),
    .BEAT_CYCLES (BEAT),
    .GAP_CYCLES  (GAP),
    .TABLE_SHIFT (SHIFT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .note_valid (note_valid),
    .note_code  (note_code),
    .note_ready (note_ready),
    .speed      (speed),
`ifdef NOTE_PAUSE_EN
    .pause      (pause),
`endif
    .tone       (tone),
    .busy       (busy),
    .cur_note   (cur_note)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_half(input logic [7:0] c);
    int v;
    v = TBL[c[7:4]] >> (int'(c[3:2]) + SHIFT);
    return (v < 2) ? 2 : v;
  endfunction

  function automatic int ref_dur(input logic [7:0] c, input logic [2:0] spd);
    int b;
    b = BEAT >> spd;
    if (b < 1) b = 1;
    return b << c[1:0];
  endfunction

  task automatic model_start();
    m_cur    = m_q.pop_front();
    m_active = 1'b1;
    m_t      = 0;
    m_tone   = 1'b0;
    m_rest   = (m_cur[7:4] == 4'd0) || (m_cur[7:4] > 4'd12);
    m_d      = ref_dur(m_cur, speed);
    m_h      = ref_half(m_cur);
  endtask

  // One clock: advance the model with the inputs present at the edge, then
  // compare all outputs on the falling edge.
  task automatic step();
    bit ready_pre;
    logic [10:0] exp_v;
    logic [10:0] act_v;
    @(posedge clk);
    if (!rst_n) begin
      m_q.delete();
      m_active = 1'b0;
      m_cur    = 8'h00;
      m_tone   = 1'b0;
      m_t      = 0;
    end else begin
      ready_pre = (m_q.size() < DEPTH);
      if (!m_active) begin
        if (m_q.size() > 0 && !pause) model_start();
      end else if (pause) begin
        m_tone = 1'b0;
      end else begin
        m_t++;
        if (m_t == m_d + GAP) begin
          if (m_q.size() > 0) begin
            model_start();
          end else begin
            m_active = 1'b0;
            m_cur    = 8'h00;
            m_tone   = 1'b0;
          end
        end else if (m_t >= m_d) begin
          m_tone = 1'b0;
        end else if (!m_rest && (m_t % m_h) == 0) begin
          m_tone = !m_tone;
        end
      end
      if (note_valid && ready_pre) m_q.push_back(note_code);
    end
    @(negedge clk);
    exp_v = {m_tone, (m_active || m_q.size() > 0), (m_active ? m_cur : 8'h00),
             (m_q.size() < DEPTH)};
    act_v = {tone, busy, cur_note, note_ready};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL cycle_outputs t=%0t {tone,busy,cur_note,ready} actual=%b_%b_%h_%b required=%b_%b_%h_%b",
               $time, act_v[10], act_v[9], act_v[8:1], act_v[0],
               exp_v[10], exp_v[9], exp_v[8:1], exp_v[0]);
    end
    if (busy === 1'b1) obs_busy++;
    if (tone === 1'b1) obs_high++;
    if (cur_note !== last_cur && cur_note !== 8'h00) obs_notes.push_back(cur_note);
    last_cur = cur_note;
  endtask

  task automatic clear_obs();
    obs_busy = 0;
    obs_high = 0;
    obs_notes.delete();
  endtask

  task automatic send(input logic [7:0] code);
    bit acc;
    acc        = 1'b0;
    note_valid = 1'b1;
    note_code  = code;
    for (int n = 0; n < BUDGET; n++) begin
      acc = note_ready;
      step();
      if (acc) break;
    end
    note_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout code=%h ready stayed low for %0d cycles", code, BUDGET);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < BUDGET) begin
      step();
      n++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL %s idle_timeout busy=%b required 0", tag, busy);
    end
  endtask

  task automatic check_int(input string tag, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", tag, act, req);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++;
    if ({tone, busy, cur_note, note_ready} !== {1'b0, 1'b0, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL reset_values actual=%b_%b_%h_%b required=0_0_00_1",
               tone, busy, cur_note, note_ready);
    end
    rst_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_single_note();
    speed = 3'd0;
    clear_obs();
    send(8'hA0);
    wait_idle("single_note");
    // 1 cycle queued + 1000 play + 20 gap; high during [221,442) and [663,884)
    check_int("single_busy_cycles", obs_busy, 1021);
    check_int("single_high_cycles", obs_high, 442);
    checks++;
    if (cur_note !== 8'h00) begin
      errors++;
      $display("FAIL single_cur_note_idle actual=%h required=00", cur_note);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] sent [$];
    logic [7:0] c;
    clear_obs();
    speed = 3'd0;
    for (int i = 0; i < 5; i++) begin
      c = 8'((i + 1) << 4) | 8'($urandom_range(0, 3) << 2);
      sent.push_back(c);
      send(c);
    end
    checks++;
    if (note_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_after_5 actual=%b required=0", note_ready);
    end
    wait_idle("back_to_back");
    check_int("b2b_note_count", obs_notes.size(), 5);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= obs_notes.size() || obs_notes[i] !== sent[i]) begin
        errors++;
        $display("FAIL b2b_order idx=%0d actual=%h required=%h", i,
                 (i < obs_notes.size()) ? obs_notes[i] : 8'hxx, sent[i]);
      end
    end
  endtask

  task automatic test_rest_octave_tempo();
    speed = 3'd0;
    clear_obs();
    send(8'h00);
    wait_idle("rest");
    check_int("rest_high_cycles", obs_high, 0);
    check_int("rest_busy_cycles", obs_busy, 1021);
    // C oct 1 len 2 at speed 2: half 186, 250*4 = 1000 cycles; speed change
    // mid-note must not alter the running note.
    speed = 3'd2;
    clear_obs();
    send(8'h16);
    repeat (10) step();
    speed = 3'd0;
    wait_idle("octave_tempo");
    check_int("oct_busy_cycles", obs_busy, 1021);
    check_int("oct_high_cycles", obs_high, 442);
  endtask

  task automatic test_reset_mid_note();
    speed = 3'd0;
    send(8'hA0);
    send(8'hB0);
    repeat (300) step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tone, busy, cur_note, note_ready} !== {1'b0, 1'b0, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL midreset_immediate actual=%b_%b_%h_%b required=0_0_00_1",
               tone, busy, cur_note, note_ready);
    end
    repeat (3) step();
    rst_n = 1'b1;
    clear_obs();
    repeat (200) step();
    check_int("midreset_no_resume_busy", obs_busy, 0);
  endtask

  task automatic test_random();
    int k;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      speed = 3'($urandom_range(0, 3));
      send({4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 1))});
      k = $urandom_range(0, 30);
      for (int j = 0; j < k; j++) begin
        if ($urandom_range(0, 9) == 0) speed = 3'($urandom_range(0, 7));
        step();
      end
    end
    wait_idle("random");
  endtask

`ifdef NOTE_PAUSE_EN
  task automatic test_pause();
    speed = 3'd0;
    clear_obs();
    send(8'hA0);
    repeat (300) step();
    pause = 1'b1;
    repeat (100) step();
    pause = 1'b0;
    wait_idle("pause");
    check_int("pause_busy_cycles", obs_busy, 1121);
  endtask
`endif

  initial begin
    rst_n      = 1'b0;
    note_valid = 1'b0;
    note_code  = 8'h00;
    speed      = 3'd0;
    pause      = 1'b0;
    m_active   = 1'b0;
    m_cur      = 8'h00;
    m_tone     = 1'b0;
    m_rest     = 1'b0;
    m_t        = 0;
    m_d        = 1;
    m_h        = 2;
    last_cur   = 8'h00;
    clear_obs();
    test_reset();
    test_single_note();
    test_back_to_back();
    test_rest_octave_tempo();
    test_reset_mid_note();
    test_random();
`ifdef NOTE_PAUSE_EN
    test_pause();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
